// File: rtl/memory_interface.sv
// Load/store alignment unit between the RV32 datapath and a word-organized data RAM.
// Produces lane enables and shifted store data, and registers extended load data.
module memory_interface (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic [2:0]  mem_size,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_out,
   input  logic [31:0] mem_data_in,
   output logic        mem_read_en,
   output logic        mem_write_en,
   output logic [3:0]  byte_enable,
   output logic [31:0] read_data
);

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

   size_e       size;
   logic        is_unsigned;
   logic        aligned;
   logic [3:0]  lane_mask;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_val;

   // Reserved funct3 codes fall through to a word access.
   always_comb begin
      case (mem_size)
         3'b000, 3'b100: size = SZ_BYTE;
         3'b001, 3'b101: size = SZ_HALF;
         default:        size = SZ_WORD;
      endcase
      is_unsigned = mem_size[2] & ~mem_size[1];
   end

   assign sel_byte = 8'(mem_data_in >> {addr[1:0], 3'b000});
   assign sel_half = 16'(mem_data_in >> {addr[1], 4'b0000});

   // NOTE: every signal gets a default before the case, so no path can infer a latch.
   always_comb begin
      aligned      = 1'b1;
      lane_mask    = 4'b1111;
      mem_data_out = write_data;
      load_val     = mem_data_in;
      case (size)
         SZ_BYTE: begin
            lane_mask    = 4'b0001 << addr[1:0];
            mem_data_out = {24'b0, write_data[7:0]} << {addr[1:0], 3'b000};
            load_val     = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
         end
         SZ_HALF: begin
            aligned      = ~addr[0];
            lane_mask    = addr[1] ? 4'b1100 : 4'b0011;
            mem_data_out = addr[1] ? {write_data[15:0], 16'b0} : {16'b0, write_data[15:0]};
            load_val     = {{16{~is_unsigned & sel_half[15]}}, sel_half};
         end
         default: begin
            aligned = (addr[1:0] == 2'b00);
         end
      endcase
   end

   // Strobes and lane enables are gated by reset so the RAM sees no access while it is held.
   assign mem_addr     = {addr[31:2], 2'b00};
   assign mem_write_en = reset & aligned & mem_write;
   assign mem_read_en  = reset & aligned & mem_read & ~mem_write;
   assign byte_enable  = (reset & aligned) ? lane_mask : 4'b0000;

   // NOTE: sequential state uses non-blocking assignment so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         read_data <= '0;
      else if (mem_read_en)
         read_data <= load_val;
   end

endmodule

// File: tb/tb_memory_interface.sv
// Self-checking bench for memory_interface: directed cases plus randomized
// requests compared against an arithmetic model of the alignment rules.
module tb_memory_interface;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, write_data, mem_data_in;
   logic [2:0]  mem_size;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_data_out, read_data;
   logic        mem_read_en, mem_write_en;
   logic [3:0]  byte_enable;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rd;

   memory_interface dut (
      .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
      .mem_size(mem_size), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .byte_enable(byte_enable), .read_data(read_data)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [2:0] s);
      if (s == 3'b000 || s == 3'b100) return 1;
      if (s == 3'b001 || s == 3'b101) return 2;
      return 4;
   endfunction

   function automatic bit is_aligned(input logic [31:0] a, input logic [2:0] s);
      return (a % nbytes(s)) == 0;
   endfunction

   // Lane offset of the field: byte offset rounded down to the access size.
   function automatic int lane_off(input logic [31:0] a, input logic [2:0] s);
      int n = nbytes(s);
      return int'(a % 4) / n * n;
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] s);
      longint m;
      if (!is_aligned(a, s)) return 4'h0;
      m = ((longint'(1) << nbytes(s)) - 1) << lane_off(a, s);
      return 4'(m);
   endfunction

   function automatic logic [31:0] model_dout(input logic [31:0] a, input logic [2:0] s,
                                              input logic [31:0] wd);
      longint mask = (longint'(1) << (8 * nbytes(s))) - 1;
      return 32'((longint'(wd) & mask) << (8 * lane_off(a, s)));
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] s,
                                              input logic [31:0] din);
      int     n = nbytes(s);
      longint mask = (longint'(1) << (8 * n)) - 1;
      longint f = (longint'(din) >> (8 * lane_off(a, s))) & mask;
      bit     sgn = !(s == 3'b100 || s == 3'b101);
      if (sgn && n < 4 && f[8*n-1]) f = f | ~mask;
      return 32'(f);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd,
                        input logic [31:0] din, input logic rd, input logic wr);
      addr = a; mem_size = s; write_data = wd; mem_data_in = din;
      mem_read = rd; mem_write = wr;
   endtask

   task automatic idle();
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      drive(32'h0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      checks++;
      if (read_data !== 32'h0) begin errors++;
         $display("FAIL reset_init read_data=%h expected=%h", read_data, 32'h0); end
      reset = 1'b1;
      step();
      // Load a nonzero value, then assert reset mid-cycle.
      drive(32'h0, 3'b010, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
      step();
      idle();
      checks++;
      if (read_data !== 32'hCAFEF00D) begin errors++;
         $display("FAIL reset_preload read_data=%h expected=%h", read_data, 32'hCAFEF00D); end
      #2 reset = 1'b0;
      drive(32'h0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (read_data !== 32'h0) begin errors++;
         $display("FAIL reset_async read_data=%h expected=%h", read_data, 32'h0); end
      checks++;
      if (byte_enable !== 4'h0 || mem_write_en !== 1'b0) begin errors++;
         $display("FAIL reset_gating be=%b wen=%b expected be=0000 wen=0", byte_enable, mem_write_en); end
      // A load held during reset must be cancelled.
      drive(32'h0, 3'b010, 32'h0, 32'h12345678, 1'b1, 1'b0);
      step();
      checks++;
      if (read_data !== 32'h0 || mem_read_en !== 1'b0) begin errors++;
         $display("FAIL reset_cancel read_data=%h ren=%b expected 0/0", read_data, mem_read_en); end
      idle();
      reset = 1'b1;
      step();
      exp_rd = 32'h0;
   endtask

   task automatic test_store_word();
      drive(32'h0, 3'b010, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (byte_enable !== 4'hF || mem_data_out !== 32'hAABBCCDD || mem_addr !== 32'h0 || mem_write_en !== 1'b1) begin
         errors++;
         $display("FAIL store_word be=%b dout=%h maddr=%h wen=%b expected 1111/aabbccdd/0/1",
                  byte_enable, mem_data_out, mem_addr, mem_write_en);
      end
      step();
      idle();
      #1;
      checks++;
      if (mem_write_en !== 1'b0 || byte_enable !== 4'hF) begin errors++;
         $display("FAIL store_word_drop wen=%b be=%b expected 0/1111", mem_write_en, byte_enable); end
   endtask

   task automatic test_load_word();
      drive(32'h0, 3'b010, 32'h0, 32'h11223344, 1'b1, 1'b0);
      step();
      idle();
      checks++;
      if (read_data !== 32'h11223344) begin errors++;
         $display("FAIL load_word read_data=%h expected=%h", read_data, 32'h11223344); end
      step();
      checks++;
      if (read_data !== 32'h11223344) begin errors++;
         $display("FAIL load_word_hold read_data=%h expected=%h", read_data, 32'h11223344); end
      exp_rd = 32'h11223344;
   endtask

   task automatic test_store_byte();
      drive(32'h4, 3'b000, 32'h000000EE, 32'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (byte_enable !== 4'b0001 || mem_addr !== 32'h4 || mem_data_out !== 32'h000000EE) begin errors++;
         $display("FAIL store_byte0 be=%b maddr=%h dout=%h expected 0001/4/000000ee",
                  byte_enable, mem_addr, mem_data_out); end
      addr = 32'h7;
      #1;
      checks++;
      if (byte_enable !== 4'b1000 || mem_addr !== 32'h4 || mem_data_out !== 32'hEE000000) begin errors++;
         $display("FAIL store_byte3 be=%b maddr=%h dout=%h expected 1000/4/ee000000",
                  byte_enable, mem_addr, mem_data_out); end
      drive(32'h6, 3'b001, 32'h0000BEEF, 32'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (byte_enable !== 4'b1100 || mem_data_out !== 32'hBEEF0000) begin errors++;
         $display("FAIL store_half_hi be=%b dout=%h expected 1100/beef0000", byte_enable, mem_data_out); end
      idle();
   endtask

   task automatic test_load_ext();
      logic [31:0] a_t [4]   = '{32'h1, 32'h1, 32'h2, 32'h2};
      logic [2:0]  s_t [4]   = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] e_t [4]   = '{32'hFFFFFFDD, 32'h000000DD, 32'hFFFFFFEE, 32'h0000FFEE};
      for (int i = 0; i < 4; i++) begin
         drive(a_t[i], s_t[i], 32'h0, 32'hFFEEDDCC, 1'b1, 1'b0);
         step();
         idle();
         checks++;
         if (read_data !== e_t[i]) begin errors++;
            $display("FAIL load_ext[%0d] read_data=%h expected=%h", i, read_data, e_t[i]); end
      end
      exp_rd = e_t[3];
   endtask

   task automatic test_misaligned();
      drive(32'h2, 3'b010, 32'h0, 32'h99999999, 1'b1, 1'b0);
      #1;
      checks++;
      if (mem_read_en !== 1'b0 || byte_enable !== 4'h0) begin errors++;
         $display("FAIL misaligned_word ren=%b be=%b expected 0/0000", mem_read_en, byte_enable); end
      step();
      checks++;
      if (read_data !== exp_rd) begin errors++;
         $display("FAIL misaligned_hold read_data=%h expected=%h", read_data, exp_rd); end
      drive(32'h3, 3'b101, 32'h0, 32'h99999999, 1'b0, 1'b1);
      #1;
      checks++;
      if (mem_write_en !== 1'b0 || byte_enable !== 4'h0) begin errors++;
         $display("FAIL misaligned_half wen=%b be=%b expected 0/0000", mem_write_en, byte_enable); end
      idle();
   endtask

   task automatic test_conflict();
      drive(32'h8, 3'b010, 32'h5A5A5A5A, 32'h77777777, 1'b1, 1'b1);
      #1;
      checks++;
      if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) begin errors++;
         $display("FAIL conflict wen=%b ren=%b expected 1/0", mem_write_en, mem_read_en); end
      step();
      checks++;
      if (read_data !== exp_rd) begin errors++;
         $display("FAIL conflict_hold read_data=%h expected=%h", read_data, exp_rd); end
      idle();
   endtask

   task automatic test_random();
      logic [31:0] a, wd, din;
      logic [2:0]  s;
      logic        rd, wr, ok;
      for (int i = 0; i < 300; i++) begin
         a   = $urandom;
         s   = 3'($urandom_range(0, 7));
         wd  = $urandom;
         din = $urandom;
         rd  = 1'($urandom_range(0, 1));
         wr  = ($urandom_range(0, 3) == 0);
         ok  = is_aligned(a, s);
         drive(a, s, wd, din, rd, wr);
         #1;
         checks++;
         if (mem_addr !== (a & 32'hFFFF_FFFC) || byte_enable !== model_be(a, s) ||
             mem_data_out !== model_dout(a, s, wd) ||
             mem_write_en !== (wr & ok) || mem_read_en !== (rd & ~wr & ok)) begin
            errors++;
            $display("FAIL rand_comb[%0d] a=%h s=%b be=%b/%b dout=%h/%h wen=%b/%b ren=%b/%b",
                     i, a, s, byte_enable, model_be(a, s), mem_data_out, model_dout(a, s, wd),
                     mem_write_en, wr & ok, mem_read_en, rd & ~wr & ok);
         end
         if (rd && !wr && ok) exp_rd = model_load(a, s, din);
         step();
         checks++;
         if (read_data !== exp_rd) begin errors++;
            $display("FAIL rand_load[%0d] a=%h s=%b read_data=%h expected=%h", i, a, s, read_data, exp_rd); end
      end
      idle();
   endtask

   initial begin
      exp_rd = 32'h0;
      idle();
      #3;
      test_reset();
      test_store_word();
      test_load_word();
      test_store_byte();
      test_load_ext();
      test_misaligned();
      test_conflict();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_interface.md
Name: memory_interface

Overview:
Load/store alignment unit between the RV32 core datapath and a 32-bit word-organized data memory. It converts a byte address, access size and write data into a word-aligned memory address, byte-lane enables and lane-shifted write data. It extracts, sign- or zero-extends and registers load data from the memory word. It sits between the execute/memory stage and the data RAM, which has combinational read.

Parameters:
None; the data path is fixed at 32 bits.

Ports:
clk  input  1  system clock; rising-edge active
reset  input  1  asynchronous, active-low reset
addr  input  32  byte address of the access
write_data  input  32  store data, right-aligned: byte in [7:0], half in [15:0]
mem_size  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_read  input  1  load request
mem_write  input  1  store request
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_data_out  output  32  write data shifted into its byte lane
mem_data_in  input  32  word read from memory, valid in the same cycle
mem_read_en  output  1  memory read strobe
mem_write_en  output  1  memory write strobe
byte_enable  output  4  active lanes; bit i = byte i of the word
read_data  output  32  extended load result (registered)

Behaviour:
- Size decode: 000/100 = byte; 001/101 = half; 010 = word. Codes 011/110/111 are treated as word. Codes 100/101 are unsigned; all others are signed.
- byte_enable is combinational from addr[1:0] and size only. It does not depend on mem_read or mem_write, so it stays valid after the strobes drop.
  - byte: 0001 << addr[1:0]
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1
  - word: 1111
- Misaligned access: a half with addr[0]=1, or a word with addr[1:0]!=00. In this case byte_enable=0000, mem_read_en=0 and mem_write_en=0, and read_data is not updated.
- mem_data_out (combinational):
  - byte: write_data[7:0] in lane addr[1:0], other bits 0
  - half: write_data[15:0] in [15:0] or [31:16], selected by addr[1]
  - word: write_data unchanged
- mem_read_en = mem_read & ~mem_write & aligned.
- mem_write_en = mem_write & aligned.
- When mem_read and mem_write are asserted together, the write takes priority: no read strobe, read_data holds.
- Load extraction (combinational, from mem_data_in):
  - byte: lane addr[1:0]
  - half: lane pair selected by addr[1]
  - word: full word
  - Signed sizes replicate the MSB of the selected field; unsigned sizes zero-fill.
- read_data register:
  - Loads the extracted value on the rising clk edge when mem_read_en=1.
  - Holds otherwise.
  - Latency: one clock edge after the request; the value remains valid until the next load.
- Reset (reset=0, asynchronous):
  - read_data is cleared to 0 immediately.
  - mem_read_en, mem_write_en and byte_enable are forced to 0 while reset is low.
  - mem_addr and mem_data_out remain combinational.
  - Deassertion of reset is synchronized to clk by the surrounding design.
- A reset asserted in the middle of a load cancels it; read_data stays 0.

Test Plan:
- Reset low with read_data previously nonzero -> read_data=0 without waiting for a clock edge; byte_enable=0000.
- addr=0, size=010, write_data=AABBCCDD, mem_write for 1 cycle, then mem_write=0 -> byte_enable=1111, mem_data_out=AABBCCDD, mem_addr=0; mem_write_en=1 only while the request is high.
- addr=0, size=010, mem_data_in=11223344, mem_read=1 for one edge -> read_data=11223344.
- addr=4, size=000, write_data=000000EE -> byte_enable=0001, mem_addr=4, mem_data_out=000000EE. Same request at addr=7 -> byte_enable=1000, mem_data_out=EE000000.
- addr=1, size=000, mem_data_in=FFEEDDCC, mem_read=1, one edge -> read_data=FFFFFFDD. Same with size=100 -> 000000DD. size=001, addr=2 -> FFFFFFEE. size=101 -> 0000FFEE.
- Misaligned or conflicting requests:
  - size=010, addr=2, mem_read=1 -> mem_read_en=0, byte_enable=0000, read_data unchanged.
  - mem_read=mem_write=1 at an aligned address -> mem_write_en=1, mem_read_en=0.
